// File: rtl/ps2_dir_decoder_pkg.sv
// Shared types and constants for the PS/2 direction decoder: parser states,
// scancodes, direction encoding and the per-player key event payload.
package ps2_dir_decoder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned NDIR   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_W     = 8'h1D;
    localparam logic [BYTE_W-1:0] SC_D     = 8'h23;
    localparam logic [BYTE_W-1:0] SC_S     = 8'h1B;
    localparam logic [BYTE_W-1:0] SC_A     = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
    localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;
    localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;

    typedef struct packed {
        logic valid;
        logic make;
        dir_e dir;
    } key_evt_t;

    // Highest-priority held direction: up > right > down > left.
    function automatic dir_e top_priority(input logic [NDIR-1:0] mask);
        dir_e pick;
        pick = DIR_UP;
        for (int i = int'(NDIR) - 1; i >= 0; i--) begin
            if (mask[i]) pick = dir_e'(DIR_W'(i));
        end
        return pick;
    endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Scancode input strobe/byte and the eight per-player direction outputs.
interface ps2_dir_decoder_if;

    logic                                     ps2_key_pressed;
    logic [ps2_dir_decoder_pkg::BYTE_W-1:0]   ps2_out;
    logic upSig,  rightSig,  downSig,  leftSig;
    logic upSig2, rightSig2, downSig2, leftSig2;

    modport master (
        output ps2_key_pressed, ps2_out,
        input  upSig, rightSig, downSig, leftSig,
        input  upSig2, rightSig2, downSig2, leftSig2
    );

    modport slave (
        input  ps2_key_pressed, ps2_out,
        output upSig, rightSig, downSig, leftSig,
        output upSig2, rightSig2, downSig2, leftSig2
    );

endinterface

// File: rtl/dir_arbiter.sv
// Per-player held-key tracking; the newest pressed key wins, and on its release
// the remaining held keys are arbitrated by fixed priority.
module dir_arbiter
    import ps2_dir_decoder_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  key_evt_t        evt,
    output logic [NDIR-1:0] dir_oh
);

    logic [NDIR-1:0] held_q, held_d;
    logic [NDIR-1:0] out_q,  out_d;
    dir_e            act_q,  act_d;
    logic            vld_q,  vld_d;

    always_comb begin
        held_d = held_q;
        act_d  = act_q;
        vld_d  = vld_q;
        if (evt.valid) begin
            if (evt.make) begin
                // Typematic repeats of a held key leave the active direction alone.
                if (!held_q[evt.dir]) begin
                    held_d[evt.dir] = 1'b1;
                    act_d           = evt.dir;
                    vld_d           = 1'b1;
                end
            end else if (held_q[evt.dir]) begin
                held_d[evt.dir] = 1'b0;
                if (vld_q && (act_q == evt.dir)) begin
                    vld_d = |held_d;
                    act_d = top_priority(held_d);
                end
            end
        end
        out_d = vld_d ? (NDIR'(1) << act_d) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q <= '0;
            out_q  <= '0;
            act_q  <= DIR_UP;
            vld_q  <= 1'b0;
        end else begin
            held_q <= held_d;
            out_q  <= out_d;
            act_q  <= act_d;
            vld_q  <= vld_d;
        end
    end

    assign dir_oh = out_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 set-2 scancode parser with prefix timeout; routes arrow keys to player 0
// and W/A/S/D to player 1.
module ps2_dir_decoder
    import ps2_dir_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic              clock,
    input  logic              reset,
    ps2_dir_decoder_if.slave  bus
);

    localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    parse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             take_c, ext_c, brk_c;
    key_evt_t         evt0_c, evt1_c;
    logic [NDIR-1:0]  dir0, dir1;

    // Prefix tracking; a repeated prefix byte counts as an unmapped code.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_c  = 1'b0;
        ext_c   = 1'b0;
        brk_c   = 1'b0;
        if (bus.ps2_key_pressed) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ps2_out == SC_EXT)      state_d = ST_EXT;
                    else if (bus.ps2_out == SC_BRK) state_d = ST_BRK;
                    else                            take_c  = 1'b1;
                end
                ST_EXT: begin
                    ext_c = 1'b1;
                    if (bus.ps2_out == SC_BRK) state_d = ST_EXT_BRK;
                    else                       take_c  = (bus.ps2_out != SC_EXT);
                end
                ST_BRK: begin
                    brk_c  = 1'b1;
                    take_c = (bus.ps2_out != SC_BRK);
                end
                default: begin
                    ext_c  = 1'b1;
                    brk_c  = 1'b1;
                    take_c = (bus.ps2_out != SC_BRK);
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Key lookup; extended codes map only to player 0, plain codes only to player 1.
    always_comb begin
        evt0_c      = '0;
        evt1_c      = '0;
        evt0_c.make = !brk_c;
        evt1_c.make = !brk_c;
        if (take_c) begin
            if (ext_c) begin
                case (bus.ps2_out)
                    SC_UP:    begin evt0_c.valid = 1'b1; evt0_c.dir = DIR_UP;    end
                    SC_RIGHT: begin evt0_c.valid = 1'b1; evt0_c.dir = DIR_RIGHT; end
                    SC_DOWN:  begin evt0_c.valid = 1'b1; evt0_c.dir = DIR_DOWN;  end
                    SC_LEFT:  begin evt0_c.valid = 1'b1; evt0_c.dir = DIR_LEFT;  end
                    default:  ;
                endcase
            end else begin
                case (bus.ps2_out)
                    SC_W:    begin evt1_c.valid = 1'b1; evt1_c.dir = DIR_UP;    end
                    SC_D:    begin evt1_c.valid = 1'b1; evt1_c.dir = DIR_RIGHT; end
                    SC_S:    begin evt1_c.valid = 1'b1; evt1_c.dir = DIR_DOWN;  end
                    SC_A:    begin evt1_c.valid = 1'b1; evt1_c.dir = DIR_LEFT;  end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    dir_arbiter u_player0 (
        .clock  (clock),
        .reset  (reset),
        .evt    (evt0_c),
        .dir_oh (dir0)
    );

    dir_arbiter u_player1 (
        .clock  (clock),
        .reset  (reset),
        .evt    (evt1_c),
        .dir_oh (dir1)
    );

    assign {bus.leftSig,  bus.downSig,  bus.rightSig,  bus.upSig}  = dir0;
    assign {bus.leftSig2, bus.downSig2, bus.rightSig2, bus.upSig2} = dir1;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scenario bench for ps2_dir_decoder: expected output vectors are queued as each
// byte is driven and compared once the DUT has had its clock to respond.
module tb_ps2_dir_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_dir_decoder_if bus ();

    ps2_dir_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // {p1 left,down,right,up, p0 left,down,right,up}
    logic [7:0] obs;
    assign obs = {bus.leftSig2, bus.downSig2, bus.rightSig2, bus.upSig2,
                  bus.leftSig,  bus.downSig,  bus.rightSig,  bus.upSig};

    localparam logic [7:0] U0 = 8'h01, R0 = 8'h02, L0 = 8'h08;
    localparam logic [7:0] U1 = 8'h10, R1 = 8'h20, D1 = 8'h40, L1 = 8'h80;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];

    // One-cycle strobe; returns at the negedge after the sampling edge.
    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_key_pressed = 1'b1;
        bus.ps2_out         = b;
        @(negedge clk);
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_out         = 8'h00;
    endtask

    // Every cycle: at most one direction per player.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp += 2;
            if ($countones(obs[3:0]) > 1) begin
                n_bad++;
                $display("FAIL onehot_p0 @%0t: got %02h, required at most one bit", $time, obs[3:0]);
            end
            if ($countones(obs[7:4]) > 1) begin
                n_bad++;
                $display("FAIL onehot_p1 @%0t: got %02h, required at most one bit", $time, obs[7:4]);
            end
        end
    end

    task automatic test_reset();
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_out         = 8'h00;
        rst                 = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_held: got %02h, expected 00", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release: got %02h, expected 00", obs);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_p1_fallback();
        logic [7:0] b[6];
        logic [7:0] e[6];
        logic [7:0] want;
        b = '{8'h1D, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h1D};
        e = '{U1,    L1,    L1,    U1,    U1,    8'h00};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL p1_fallback[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_ext_right();
        logic [7:0] b[6];
        logic [7:0] e[6];
        logic [7:0] want;
        b = '{8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74, 8'h74};
        e = '{8'h00, R0,    R0,    R0,    8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL ext_right[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_typematic();
        logic [7:0] b[8];
        logic [7:0] e[8];
        logic [7:0] want;
        b = '{8'h23, 8'h23, 8'h23, 8'h1B, 8'hF0, 8'h1B, 8'hF0, 8'h23};
        e = '{R1,    R1,    R1,    D1,    D1,    R1,    R1,    8'h00};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL typematic[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] b[13];
        logic [7:0] e[13];
        logic [7:0] want;
        b = '{8'h1B, 8'h23, 8'h1C, 8'hF0, 8'h1C, 8'h1D, 8'hF0,
              8'h1B, 8'hF0, 8'h1D, 8'hF0, 8'h23, 8'h1B};
        e = '{D1,    R1,    L1,    L1,    R1,    U1,    U1,
              U1,    U1,    R1,    R1,    8'h00, D1};
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL priority[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
        // Release the last key so later scenarios start clean.
        exp_q.push_back(D1);
        drive_byte(8'hF0);
        exp_q.push_back(8'h00);
        drive_byte(8'h1B);
        void'(exp_q.pop_front());
        want = exp_q.pop_front();
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL priority_release: got %02h, expected %02h", obs, want);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] b[11];
        logic [7:0] e[11];
        logic [7:0] want;
        b = '{8'hE0, 8'hE0, 8'h75, 8'hE0, 8'h1D, 8'h12,
              8'hF0, 8'hF0, 8'h1D, 8'hF0, 8'h1D};
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, U1,    U1,    8'h00};
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL unmapped[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[7];
        logic [7:0] e[7];
        logic [7:0] want;
        b = '{8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        e = '{8'h00, 8'h00, 8'h00, U0,    U0,    U0,    8'h00};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            if (i == 0) repeat (20) @(negedge clk);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[4];
        logic [7:0] e[4];
        logic [7:0] b2[6];
        logic [7:0] e2[6];
        logic [7:0] want;
        b  = '{8'hE0, 8'h75, 8'h1C,    8'hE0};
        e  = '{8'h00, U0,    U0 | L1,  U0 | L1};
        b2 = '{8'h75, 8'hF0, 8'h1C, 8'h1D, 8'hF0, 8'h1D};
        e2 = '{8'h00, 8'h00, 8'h00, U1,    U1,    8'h00};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL reset_mid_pre[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
        // Reset between edges must clear outputs before any clock arrives.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_async: got %02h, expected 00", obs);
        end
        bus.ps2_key_pressed = 1'b1;
        bus.ps2_out         = 8'hE0;
        @(negedge clk);
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_out         = 8'h00;
        rst                 = 1'b0;
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_strobe: got %02h, expected 00", obs);
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e2[i]);
            drive_byte(b2[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL reset_mid_post[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    task automatic test_interleave();
        logic [7:0] b[8];
        logic [7:0] e[8];
        logic [7:0] want;
        b = '{8'hE0, 8'h6B, 8'h1B,   8'hE0,   8'hF0,   8'h6B, 8'hF0, 8'h1B};
        e = '{8'h00, L0,    L0 | D1, L0 | D1, L0 | D1, D1,    D1,    8'h00};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(e[i]);
            drive_byte(b[i]);
            want = exp_q.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL interleave[%0d]: got %02h, expected %02h", i, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p1_fallback();
        test_ext_right();
        test_typematic();
        test_priority();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_interleave();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
